regfile_writeback_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_load_fifo.sv | 98 +++++++++
 rtl/regfile_writeback_arbiter.sv | 176 +++++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   XLEN       : data width of a writeback result
//   REG_ADDR_W : architectural register address width
//   wb_src_t   : which producer owns the write port in a cycle
//   wb_entry_t : one buffered writeback (destination + data)
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_LD
    } wb_src_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// In-order FIFO buffering load results until they win the write port.
// Optional build macro: WB_SCOREBOARD_EN exposes the entry array and a
// per-entry valid mask so the parent can build a pending-load mask.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_entry  : enqueue request and payload (ignored when full)
//   pop               : dequeue request (ignored when empty)
//   head              : entry at the read pointer
//   full, empty, count: occupancy status (count in 0..DEPTH)
//   entries, entry_valid (WB_SCOREBOARD_EN only): storage snapshot
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
`ifdef WB_SCOREBOARD_EN
    ,
    output wb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
`endif
);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer, occupancy and storage next-state; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state is reset; payload storage is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef WB_SCOREBOARD_EN
    assign entries = mem_q;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_valid[i] = CW'(AW'(AW'(i) - rd_ptr_q)) < count_q;
        end
    end
`endif

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writer end of the register-file write port. Merges single-cycle ALU
// results with buffered load results; a starvation counter forces the
// load FIFO to win after STARVE_LIMIT consecutive losses. Writes to x0 are
// consumed without asserting RegWrite.
// Optional build macro: WB_SCOREBOARD_EN drives ld_pending with a
// per-register mask of loads not yet visible in the register file;
// otherwise ld_pending is tied to zero.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_data     : load result handshake into the FIFO
//   RegWrite/WriteAddr/WriteData        : registered write port
//   ld_count                            : load FIFO occupancy
//   ld_pending                          : pending-load register mask
module regfile_writeback_arbiter #(
    parameter  int unsigned XLEN          = 32,
    parameter  int unsigned LD_FIFO_DEPTH = 4,
    parameter  int unsigned STARVE_LIMIT  = 3,
    localparam int unsigned CW            = $clog2(LD_FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            RegWrite,
    output logic [4:0]      WriteAddr,
    output logic [XLEN-1:0] WriteData,
    output logic [CW-1:0]   ld_count,
    output logic [31:0]     ld_pending
);

    import wb_pkg::*;

    localparam int unsigned DW = wb_pkg::XLEN;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t       ld_push_entry;
    wb_entry_t       ld_head;
    logic            ld_full;
    logic            ld_empty;
    logic            ld_push;
    logic            ld_pop;
    logic            force_ld;
    wb_src_t         sel_src;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      write_addr_q, write_addr_d;
    logic [XLEN-1:0] write_data_q, write_data_d;

`ifdef WB_SCOREBOARD_EN
    wb_entry_t                ld_entries [LD_FIFO_DEPTH];
    logic [LD_FIFO_DEPTH-1:0] ld_entry_valid;
    logic                     wb_from_ld_q, wb_from_ld_d;
`endif

    assign ld_push_entry.rd   = REG_ADDR_W'(ld_rd);
    assign ld_push_entry.data = DW'(ld_data);

    wb_load_fifo #(
        .DEPTH       (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (ld_push),
        .push_entry  (ld_push_entry),
        .pop         (ld_pop),
        .head        (ld_head),
        .full        (ld_full),
        .empty       (ld_empty),
        .count       (ld_count)
`ifdef WB_SCOREBOARD_EN
        ,
        .entries     (ld_entries),
        .entry_valid (ld_entry_valid)
`endif
    );

    // Port arbitration: starved loads first, then ALU, then any load.
    always_comb begin
        force_ld = !ld_empty && (starve_cnt_q == SW'(STARVE_LIMIT));
        sel_src  = WB_SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (force_ld) begin
            sel_src = WB_SRC_LD;
        end else if (alu_valid) begin
            sel_src = WB_SRC_ALU;
        end else if (!ld_empty) begin
            sel_src = WB_SRC_LD;
        end
        case (sel_src)
            WB_SRC_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            WB_SRC_LD: begin
                sel_rd   = 5'(ld_head.rd);
                sel_data = XLEN'(ld_head.data);
            end
            default: ;
        endcase
        alu_ready = !force_ld;
        ld_ready  = !ld_full;
        ld_push   = ld_valid && !ld_full;
        ld_pop    = (sel_src == WB_SRC_LD);
    end

    // Starvation counter and output-register next state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ld_empty || ld_pop) begin
            starve_cnt_d = '0;
        end else if (sel_src == WB_SRC_ALU && starve_cnt_q != SW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        reg_write_d  = (sel_src != WB_SRC_NONE) && (sel_rd != 5'd0);
        write_addr_d = reg_write_d ? sel_rd : write_addr_q;
        write_data_d = reg_write_d ? sel_data : write_data_q;
`ifdef WB_SCOREBOARD_EN
        wb_from_ld_d = (sel_src == WB_SRC_LD);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
`ifdef WB_SCOREBOARD_EN
            wb_from_ld_q <= 1'b0;
`endif
        end else begin
            starve_cnt_q <= starve_cnt_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
`ifdef WB_SCOREBOARD_EN
            wb_from_ld_q <= wb_from_ld_d;
`endif
        end
    end

    assign RegWrite  = reg_write_q;
    assign WriteAddr = write_addr_q;
    assign WriteData = write_data_q;

`ifdef WB_SCOREBOARD_EN
    // Registers still owed a load value: buffered entries plus the load
    // currently on the write port. x0 never needs tracking.
    always_comb begin
        ld_pending = '0;
        for (int i = 0; i < int'(LD_FIFO_DEPTH); i++) begin
            if (ld_entry_valid[i]) begin
                ld_pending[ld_entries[i].rd] = 1'b1;
            end
        end
        if (reg_write_q && wb_from_ld_q) begin
            ld_pending[write_addr_q] = 1'b1;
        end
        ld_pending[0] = 1'b0;
    end
`else
    assign ld_pending = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter. Expected writes are
// queued when stimulus is issued; a negedge monitor pops and compares each
// write the DUT presents. Handshake/occupancy points are checked inline.
module tb_regfile_writeback_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid, ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            RegWrite;
    logic [4:0]      WriteAddr;
    logic [XLEN-1:0] WriteData;
    logic [CW-1:0]   ld_count;
    logic [31:0]     ld_pending;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(
        .XLEN          (XLEN),
        .LD_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .ld_count   (ld_count),
        .ld_pending (ld_pending)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Write monitor: every asserted RegWrite must match the next queued write.
    always @(negedge clk) begin
        if (RegWrite) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h want no write", WriteAddr, WriteData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (WriteAddr !== e.a || WriteData !== e.d) begin
                    bad++;
                    $display("FAIL write_order: got addr=%0d data=%0h want addr=%0d data=%0h",
                             WriteAddr, WriteData, e.a, e.d);
                end
            end
        end
    end

    logic [5:0]  rdy3;
    logic [9:0]  lr4, ar4;
    int          cnt4 [10];
    logic [4:0]  rd6 [3];
    logic [31:0] exp_pend;

    initial begin
        int ai, li;
        set_in(0, 0, 0, 0, 0, 0);
        rdy3 = 6'b101111;
        lr4  = 10'b1110101111;
        ar4  = 10'b1111101111;
        cnt4 = '{0, 1, 2, 3, 4, 3, 4, 3, 2, 1};
        rd6  = '{5'd3, 5'd9, 5'd3};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        #3;
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_waddr", 32'(WriteAddr), 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_count", 32'(ld_count), 0);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_pending", ld_pending, 0);

        // Single ALU write, one-cycle latency
        tick();
        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0);
        push_exp(5, 32'hDEADBEEF);
        #3 chk("alu1_ready", 32'(alu_ready), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        chk("alu1_regwrite", 32'(RegWrite), 1);
        chk("alu1_wdata", WriteData, 32'hDEADBEEF);
        tick();
        #3;
        chk("alu1_regwrite_off", 32'(RegWrite), 0);
        chk("alu1_waddr_hold", 32'(WriteAddr), 5);

        // Single load, two-cycle latency
        tick();
        set_in(0, 0, 0, 1, 7, 32'h1234);
        push_exp(7, 32'h1234);
        #3 chk("ld1_ready", 32'(ld_ready), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        chk("ld1_count1", 32'(ld_count), 1);
        chk("ld1_regwrite_early", 32'(RegWrite), 0);
        tick();
        #3;
        chk("ld1_count0", 32'(ld_count), 0);
        chk("ld1_regwrite", 32'(RegWrite), 1);
        chk("ld1_waddr", 32'(WriteAddr), 7);
        tick();
        #3 chk("ld1_regwrite_off", 32'(RegWrite), 0);

        // Starvation: ALU wins 3 times against a buffered load, then yields once
        for (int r = 10; r <= 13; r++) push_exp(5'(r), 32'hA000_0000 | 32'(r));
        push_exp(9, 32'h9999);
        push_exp(14, 32'hA000_000E);
        ai = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(1, 5'(10 + ai), 32'hA000_0000 | 32'(10 + ai), (c == 0), 9, 32'h9999);
            #3 chk($sformatf("starve_alu_ready_c%0d", c), 32'(alu_ready), 32'(rdy3[c]));
            if (alu_ready) ai++;
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Fill the FIFO while the ALU is busy; no pass-through when full
        for (int i = 0; i < 4; i++) push_exp(5'(20 + i), 32'hB000_0000 + 32'(i));
        push_exp(25, 32'hC000_0000);
        push_exp(24, 32'hB000_0004);
        for (int i = 1; i < 5; i++) push_exp(5'(25 + i), 32'hC000_0000 + 32'(i));
        ai = 0;
        li = 0;
        for (int c = 0; c < 10; c++) begin
            set_in(ai < 5, 5'(20 + ai), 32'hB000_0000 + 32'(ai),
                   li < 5, 5'(25 + li), 32'hC000_0000 + 32'(li));
            #3;
            chk($sformatf("fill_count_c%0d", c), 32'(ld_count), 32'(cnt4[c]));
            chk($sformatf("fill_ld_ready_c%0d", c), 32'(ld_ready), 32'(lr4[c]));
            chk($sformatf("fill_alu_ready_c%0d", c), 32'(alu_ready), 32'(ar4[c]));
            if (alu_ready && alu_valid) ai++;
            if (ld_ready && ld_valid) li++;
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        #3 chk("fill_drained", 32'(ld_count), 0);
        repeat (2) tick();

        // x0 destinations are consumed silently
        set_in(1, 0, 32'h1111_1111, 1, 0, 32'h2222_2222);
        #3;
        chk("x0_alu_ready", 32'(alu_ready), 1);
        chk("x0_ld_ready", 32'(ld_ready), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        chk("x0_count1", 32'(ld_count), 1);
        chk("x0_regwrite_a", 32'(RegWrite), 0);
        tick();
        #3;
        chk("x0_count0", 32'(ld_count), 0);
        chk("x0_regwrite_b", 32'(RegWrite), 0);
        tick();
        #3 chk("x0_regwrite_c", 32'(RegWrite), 0);
        tick();

        // Reset with three loads buffered behind a busy (x0) ALU
        for (int c = 0; c < 3; c++) begin
            set_in(1, 0, 32'h0, 1, rd6[c], 32'hD000_0000 + 32'(c));
            #3 chk($sformatf("rst_fill_ld_ready_c%0d", c), 32'(ld_ready), 1);
            tick();
        end
        set_in(1, 0, 32'h0, 0, 0, 0);
`ifdef WB_SCOREBOARD_EN
        exp_pend = 32'h0000_0208;
`else
        exp_pend = 32'h0;
`endif
        #3;
        chk("prerst_count", 32'(ld_count), 3);
        chk("prerst_pending", ld_pending, exp_pend);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        chk("midrst_count", 32'(ld_count), 0);
        chk("midrst_regwrite", 32'(RegWrite), 0);
        chk("midrst_pending", ld_pending, 0);
        chk("midrst_ld_ready", 32'(ld_ready), 1);
        tick();
        #3;
        chk("postrst_regwrite", 32'(RegWrite), 0);
        chk("postrst_count", 32'(ld_count), 0);

        repeat (3) tick();
        chk("exp_queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
